// File: rtl/eh2_dec_gpr_wb_sched.sv
// GPR writeback scheduler: four single-entry holding slots, round-robin arbitrated onto two write ports.
// Latency: a held write is issued the cycle after its handshake if it wins; requesters backpressure via req_ready.
module eh2_dec_gpr_wb_sched #(
  parameter int NUM_TID = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               req_valid,
  input  logic [3:0]               req_tid,
  input  logic [3:0][4:0]          req_addr,
  input  logic [3:0][31:0]         req_data,
  output logic [3:0]               req_ready,
  input  logic [1:0]               port_en,
  output logic                     wen0,
  output logic                     wen1,
  output logic                     wtid0,
  output logic                     wtid1,
  output logic [4:0]               waddr0,
  output logic [4:0]               waddr1,
  output logic [31:0]              wd0,
  output logic [31:0]              wd1,
  output logic [NUM_TID-1:0][31:0] pend_mask,
  output logic                     idle
);

  logic [3:0]       slot_v_q, slot_v_d;
  logic [3:0]       slot_tid_q, slot_tid_d;
  logic [3:0][4:0]  slot_addr_q, slot_addr_d;
  logic [3:0][31:0] slot_data_q, slot_data_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;

  logic       g0_vld, g1_vld, p0_vld, p1_vld;
  logic [1:0] g0_idx, g1_idx, p0_idx, p1_idx, cand;
  logic [3:0] grant;

  // Walk slots in round-robin order; the second pick must not alias the first's (tid,addr).
  always_comb begin
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0_idx = 2'd0;
    g1_idx = 2'd0;
    cand   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (slot_v_q[cand]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = cand;
        end else if (!g1_vld &&
                     ({slot_tid_q[cand], slot_addr_q[cand]} !=
                      {slot_tid_q[g0_idx], slot_addr_q[g0_idx]})) begin
          g1_vld = 1'b1;
          g1_idx = cand;
        end
      end
    end
  end

  always_comb begin
    p0_vld   = g0_vld & port_en[0];
    p0_idx   = g0_idx;
    p1_vld   = port_en[0] ? (g1_vld & port_en[1]) : (g0_vld & port_en[1]);
    p1_idx   = port_en[0] ? g1_idx : g0_idx;
    grant    = 4'd0;
    if (p0_vld) grant[p0_idx] = 1'b1;
    if (p1_vld) grant[p1_idx] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (p1_vld)      rr_ptr_d = p1_idx + 2'd1;
    else if (p0_vld) rr_ptr_d = p0_idx + 2'd1;
  end

  assign req_ready = ~slot_v_q | grant;

  // x0 writes are accepted to keep the requester flowing, but never occupy a slot.
  always_comb begin
    slot_v_d    = slot_v_q & ~grant;
    slot_tid_d  = slot_tid_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        slot_v_d[i]    = (req_addr[i] != 5'd0);
        slot_tid_d[i]  = (NUM_TID > 1) ? req_tid[i] : 1'b0;
        slot_addr_d[i] = req_addr[i];
        slot_data_d[i] = req_data[i];
      end
    end
  end

  always_comb begin
    wen0   = p0_vld;
    wtid0  = p0_vld & slot_tid_q[p0_idx];
    waddr0 = p0_vld ? slot_addr_q[p0_idx] : 5'd0;
    wd0    = p0_vld ? slot_data_q[p0_idx] : 32'd0;
    wen1   = p1_vld;
    wtid1  = p1_vld & slot_tid_q[p1_idx];
    waddr1 = p1_vld ? slot_addr_q[p1_idx] : 5'd0;
    wd1    = p1_vld ? slot_data_q[p1_idx] : 32'd0;
  end

  always_comb begin
    pend_mask = '0;
    for (int t = 0; t < NUM_TID; t++) begin
      for (int s = 0; s < 4; s++) begin
        if (slot_v_q[s] && (slot_tid_q[s] == 1'(t))) pend_mask[t][slot_addr_q[s]] = 1'b1;
      end
    end
  end

  assign idle = ~|slot_v_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_v_q <= 4'd0;
      rr_ptr_q <= 2'd0;
    end else begin
      slot_v_q <= slot_v_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_tid_q  <= slot_tid_d;
    slot_addr_q <= slot_addr_d;
    slot_data_q <= slot_data_d;
  end

endmodule

// File: doc/eh2_dec_gpr_wb_sched.md
EH2_DEC_GPR_WB_SCHED -- requirements
Module: eh2_dec_gpr_wb_sched

Interface
REQ-001 SHALL have parameter NUM_TID, default 2, number of hardware threads (1 or 2).
REQ-002 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  4  writeback request valid, requester i = bit i.
REQ-005 SHALL have port req_tid  in  4  thread id per requester.
REQ-006 SHALL have port req_addr  in  4x5  destination GPR per requester.
REQ-007 SHALL have port req_data  in  4x32  write data per requester.
REQ-008 SHALL have port req_ready  out  4  holding slot can accept this cycle.
REQ-009 SHALL have port port_en  in  2  GPR write port 0/1 available to this block this cycle.
REQ-010 SHALL have ports wen0/wen1  out  1  GPR write enable, port 0/1.
REQ-011 SHALL have ports wtid0/wtid1  out  1; waddr0/waddr1  out  5; wd0/wd1  out  32  write thread, address, data per port.
REQ-012 SHALL have port pend_mask  out  NUM_TIDx32  bit [t][a] = a held write to thread t, GPR a, is outstanding; bit 0 always 0.
REQ-013 SHALL have port idle  out  1  no holding slot valid.

Function
REQ-014 SHALL keep one holding slot per requester: valid, tid, addr[4:0], data[31:0].
REQ-015 SHALL accept on req_valid[i] & req_ready[i]; slot loads at that edge.
REQ-016 SHALL accept requests with addr 0 but discard them: slot stays empty, no write issued.
REQ-017 SHALL drive req_ready[i] = ~slot_v[i] | grant[i] (same-cycle issue and refill; sustained 1 write/cycle/requester).
REQ-018 SHALL form a candidate order: requesters rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4), valid slots only.
REQ-019 SHALL grant the first candidate to the lowest enabled port (port 0 if port_en[0], else port 1).
REQ-020 SHALL grant the next candidate whose (tid,addr) differs from the first grant to port 1 only when port_en = 2'b11.
REQ-021 SHALL never drive wen0 and wen1 together with wtid0==wtid1 and waddr0==waddr1.
REQ-022 SHALL leave a skipped same-address candidate held, unchanged, for a later cycle.
REQ-023 SHALL drive wenN, wtidN, waddrN, wdN combinationally from the granted slot; unused ports drive 0 on all fields.
REQ-024 SHALL give latency: handshake at edge N, write visible on port in cycle after edge N when that requester wins.
REQ-025 SHALL clear a granted slot at the edge ending the grant cycle unless refilled that same edge per REQ-017.
REQ-026 SHALL update rr_ptr to (index of last granted requester + 1) mod 4 when any grant occurs; unchanged otherwise.
REQ-027 SHALL grant nothing when port_en = 2'b00; slots hold, ready = ~slot_v.
REQ-028 SHALL compute pend_mask and idle combinationally from slot state only (not from grants).
REQ-029 SHALL ignore req_tid bits >= NUM_TID (treated as tid 0) when NUM_TID = 1.

Reset
REQ-030 SHALL on rst clear all slot valids and set rr_ptr = 0, asynchronously.
REQ-031 SHALL while rst or slots empty drive wen0 = wen1 = 0, all port fields 0, pend_mask = 0, idle = 1, req_ready = 4'hF.
REQ-032 SHALL discard held writes on reset mid-operation; no write issued in the cycle following deassertion.

Verification
REQ-033 Single: req0 tid0 addr5 data 0xDEADBEEF, port_en=11 -> next cycle wen0=1, waddr0=5, wd0=0xDEADBEEF, wen1=0; then idle=1.
REQ-034 Full contention: all four hold distinct addrs 1..4, rr_ptr=0, port_en=11 -> cycle1 grants req0 (p0), req1 (p1), rr_ptr=2; cycle2 req2, req3; rr_ptr=0.
REQ-035 Conflict: req0 and req1 both tid1 addr7, req2 tid1 addr8 -> port0 = req0, port1 = req2; req1 issued next cycle on port0.
REQ-036 Port masking: port_en=10, two slots held -> only wen1 asserted, one per cycle; port_en=00 for 3 cycles -> no writes, pend_mask stable.
REQ-037 x0 and back-to-back: req3 writes addr0 then addr9 continuously -> addr0 never appears on a port; ready stays 1 and addr9 writes stream 1/cycle when uncontended.
REQ-038 Reset mid-flight: three slots held, assert rst -> idle=1, pend_mask=0 immediately; after release no wen until new handshake.
